// File: rtl/tag_pkg.sv
// rtl/tag_pkg.sv - shared types and default sizing for the tag free list
// Purpose: tag type, free-list FSM state encoding and default parameters
//          shared by the free list, its interface and its compactor.
package tag_pkg;
   localparam int NUM_TAGS_DEF    = 64;
   localparam int ALLOC_PORTS_DEF = 2;
   localparam int RET_PORTS_DEF   = 2;
   localparam int INIT_RATE_DEF   = 4;
   localparam int TAG_W_DEF       = $clog2(NUM_TAGS_DEF);

   typedef logic [TAG_W_DEF-1:0] tag_t;

   typedef enum logic {
      INIT,
      READY
   } fl_state_e;
endpackage

// File: rtl/tag_free_list_if.sv
// rtl/tag_free_list_if.sv - allocation/return bus of the tag free list
// Purpose: groups the dispatch allocation handshake and the CDB return port.
// Ports:   i_alloc_req  per-port allocation request      (master -> slave)
//          o_alloc_gnt  per-port grant                   (slave -> master)
//          o_alloc_tag  granted tag per port, 0 if none  (slave -> master)
//          i_ret_valid  per-port tag return valid        (master -> slave)
//          i_ret_tag    returned tag per port            (master -> slave)
interface tag_free_list_if
   import tag_pkg::*;
#(
   parameter int ALLOC_PORTS = ALLOC_PORTS_DEF,
   parameter int RET_PORTS   = RET_PORTS_DEF,
   parameter int TAG_W       = TAG_W_DEF
);
   logic [ALLOC_PORTS-1:0]            i_alloc_req;
   logic [ALLOC_PORTS-1:0]            o_alloc_gnt;
   logic [ALLOC_PORTS-1:0][TAG_W-1:0] o_alloc_tag;
   logic [RET_PORTS-1:0]              i_ret_valid;
   logic [RET_PORTS-1:0][TAG_W-1:0]   i_ret_tag;

   modport master (
      output i_alloc_req, i_ret_valid, i_ret_tag,
      input  o_alloc_gnt, o_alloc_tag
   );

   modport slave (
      input  i_alloc_req, i_ret_valid, i_ret_tag,
      output o_alloc_gnt, o_alloc_tag
   );
endinterface

// File: rtl/tag_port_compactor.sv
// rtl/tag_port_compactor.sv - prefix-count unit with an acceptance limit
// Purpose: keeps valid ports in port order until i_limit have been kept;
//          gives each port its rank among the kept ports and the total kept.
// Ports:   i_valid  per-port valid vector
//          i_limit  maximum number of ports that may be kept
//          o_keep   per-port kept flag
//          o_rank   number of kept ports below each port
//          o_total  number of kept ports
module tag_port_compactor
   import tag_pkg::*;
#(
   parameter int N      = ALLOC_PORTS_DEF,
   parameter int CNT_W  = TAG_W_DEF + 1,
   parameter int RANK_W = TAG_W_DEF
) (
   input  logic [N-1:0]             i_valid,
   input  logic [CNT_W-1:0]         i_limit,
   output logic [N-1:0]             o_keep,
   output logic [N-1:0][RANK_W-1:0] o_rank,
   output logic [CNT_W-1:0]         o_total
);
   logic [CNT_W-1:0] acc;

   // Once the limit is hit every later port is dropped, so while acc is
   // below the limit it equals the number of valid ports below k.
   always_comb begin
      acc     = '0;
      o_keep  = '0;
      o_rank  = '0;
      for (int k = 0; k < N; k++) begin
         o_rank[k] = RANK_W'(acc);
         o_keep[k] = i_valid[k] && (acc < i_limit);
         acc       = acc + CNT_W'(o_keep[k]);
      end
      o_total = acc;
   end
endmodule

// File: rtl/tag_free_list.sv
// rtl/tag_free_list.sv - multi-port circular free list of physical/ROB tags
// Purpose: hands out up to ALLOC_PORTS tags per cycle in FIFO order, takes
//          back up to RET_PORTS tags per cycle, refills itself after flush.
// Ports:   i_clk, i_rst_n (async, active-low), i_flush
//          bus         allocation/return interface (slave side)
//          o_free_cnt  free tags 0..NUM_TAGS
//          o_ready     initialisation done, allocations accepted
//          o_empty     ready with no free tags
//          o_ovf_err   sticky: a return arrived while the list was full
module tag_free_list
   import tag_pkg::*;
#(
   parameter int NUM_TAGS    = NUM_TAGS_DEF,
   parameter int TAG_W       = $clog2(NUM_TAGS),
   parameter int ALLOC_PORTS = ALLOC_PORTS_DEF,
   parameter int RET_PORTS   = RET_PORTS_DEF,
   parameter int INIT_RATE   = INIT_RATE_DEF
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_flush,
   tag_free_list_if.slave bus,
   output logic [TAG_W:0] o_free_cnt,
   output logic           o_ready,
   output logic           o_empty,
   output logic           o_ovf_err
);
   localparam int               CNT_W   = TAG_W + 1;
   localparam logic [TAG_W-1:0] LAST_II = TAG_W'(NUM_TAGS - INIT_RATE);

   fl_state_e        state_q, state_d;
   logic [TAG_W-1:0] ii_q, ii_d;
   logic [TAG_W-1:0] hp_q, hp_d;
   logic [TAG_W-1:0] tp_q, tp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [TAG_W-1:0] mem_q [NUM_TAGS];

   logic                              active;
   logic [ALLOC_PORTS-1:0]            alloc_req;
   logic [ALLOC_PORTS-1:0]            alloc_gnt;
   logic [ALLOC_PORTS-1:0][TAG_W-1:0] alloc_rank;
   logic [CNT_W-1:0]                  gnt_total;
   logic [RET_PORTS-1:0]              ret_valid;
   logic [RET_PORTS-1:0]              ret_keep;
   logic [RET_PORTS-1:0][TAG_W-1:0]   ret_rank;
   logic [CNT_W-1:0]                  ret_total;
   logic [CNT_W-1:0]                  ret_limit;

   // Flush and INIT both silence grants and returns.
   assign active    = (state_q == READY) && !i_flush;
   assign alloc_req = bus.i_alloc_req & {ALLOC_PORTS{active}};
   assign ret_valid = bus.i_ret_valid & {RET_PORTS{active}};
   // Space left after this cycle's grants; never exceeds NUM_TAGS.
   assign ret_limit = CNT_W'(NUM_TAGS) - cnt_q + gnt_total;

   tag_port_compactor #(.N(ALLOC_PORTS), .CNT_W(CNT_W), .RANK_W(TAG_W)) u_alloc_cmp (
      .i_valid (alloc_req),
      .i_limit (cnt_q),
      .o_keep  (alloc_gnt),
      .o_rank  (alloc_rank),
      .o_total (gnt_total)
   );

   tag_port_compactor #(.N(RET_PORTS), .CNT_W(CNT_W), .RANK_W(TAG_W)) u_ret_cmp (
      .i_valid (ret_valid),
      .i_limit (ret_limit),
      .o_keep  (ret_keep),
      .o_rank  (ret_rank),
      .o_total (ret_total)
   );

   assign bus.o_alloc_gnt = alloc_gnt;

   for (genvar k = 0; k < ALLOC_PORTS; k++) begin : g_rd
      logic [TAG_W-1:0] rd_addr;
      assign rd_addr            = hp_q + alloc_rank[k];
      assign bus.o_alloc_tag[k] = alloc_gnt[k] ? mem_q[rd_addr] : '0;
   end

   always_comb begin
      state_d = state_q;
      ii_d    = ii_q;
      hp_d    = hp_q;
      tp_d    = tp_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q | (|(ret_valid & ~ret_keep));
      if (i_flush) begin
         state_d = INIT;
         ii_d    = '0;
         hp_d    = '0;
         tp_d    = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            INIT: begin
               ii_d = ii_q + TAG_W'(INIT_RATE);
               if (ii_q == LAST_II) begin
                  state_d = READY;
                  ii_d    = '0;
                  hp_d    = '0;
                  tp_d    = '0;
                  cnt_d   = CNT_W'(NUM_TAGS);
               end
            end
            READY: begin
               hp_d  = hp_q + gnt_total[TAG_W-1:0];
               tp_d  = tp_q + ret_total[TAG_W-1:0];
               cnt_d = cnt_q - gnt_total + ret_total;
            end
            default: state_d = INIT;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= INIT;
         ii_q    <= '0;
         hp_q    <= '0;
         tp_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ii_q    <= ii_d;
         hp_q    <= hp_d;
         tp_q    <= tp_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Storage needs no reset: INIT rewrites every entry before use.
   always_ff @(posedge i_clk) begin
      if (state_q == INIT && !i_flush) begin
         for (int i = 0; i < INIT_RATE; i++) begin
            mem_q[ii_q + TAG_W'(i)] <= ii_q + TAG_W'(i);
         end
      end else begin
         for (int k = 0; k < RET_PORTS; k++) begin
            if (ret_keep[k]) begin
               mem_q[tp_q + ret_rank[k]] <= bus.i_ret_tag[k];
            end
         end
      end
   end

   assign o_free_cnt = cnt_q;
   assign o_ready    = (state_q == READY);
   assign o_empty    = (state_q == READY) && (cnt_q == '0);
   assign o_ovf_err  = ovf_q;
endmodule

// File: tb/tb_tag_free_list.sv
// tb/tb_tag_free_list.sv - self-checking bench for tag_free_list
module tb_tag_free_list;
   import tag_pkg::*;

   localparam int NT        = 64;
   localparam int AP        = 2;
   localparam int RP        = 2;
   localparam int INIT_CYC  = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic [6:0] free_cnt;
   logic       ready;
   logic       empty;
   logic       ovf_err;

   int total = 0;
   int bad   = 0;

   tag_free_list_if #(.ALLOC_PORTS(AP), .RET_PORTS(RP), .TAG_W(6)) bus ();

   tag_free_list dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_flush    (flush),
      .bus        (bus.slave),
      .o_free_cnt (free_cnt),
      .o_ready    (ready),
      .o_empty    (empty),
      .o_ovf_err  (ovf_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a FIFO of free tags plus a ready flag and init timer.
   bit   m_ready     = 1'b0;
   int   m_init_left = INIT_CYC;
   bit   m_ovf       = 1'b0;
   tag_t m_free[$];

   always @(posedge clk or negedge rst_n) begin
      int n_req, n_take;
      if (!rst_n) begin
         m_ready     = 1'b0;
         m_init_left = INIT_CYC;
         m_ovf       = 1'b0;
         m_free.delete();
      end else if (flush) begin
         m_ready     = 1'b0;
         m_init_left = INIT_CYC;
         m_free.delete();
      end else if (!m_ready) begin
         m_init_left--;
         if (m_init_left == 0) begin
            m_ready = 1'b1;
            for (int t = 0; t < NT; t++) m_free.push_back(tag_t'(t));
         end
      end else begin
         n_req = 0;
         for (int k = 0; k < AP; k++) if (bus.i_alloc_req[k]) n_req++;
         n_take = (n_req < m_free.size()) ? n_req : m_free.size();
         repeat (n_take) void'(m_free.pop_front());
         for (int k = 0; k < RP; k++) begin
            if (bus.i_ret_valid[k]) begin
               if (m_free.size() < NT) m_free.push_back(bus.i_ret_tag[k]);
               else m_ovf = 1'b1;
            end
         end
      end
   end

   // Compare process: every cycle, halfway between rising edges.
   logic [AP-1:0] exp_gnt;
   int            exp_tag [AP];
   int            c_req, c_gnt;

   always @(negedge clk) begin
      exp_gnt = '0;
      c_req   = 0;
      c_gnt   = 0;
      for (int k = 0; k < AP; k++) exp_tag[k] = 0;
      if (m_ready && !flush) begin
         for (int k = 0; k < AP; k++) begin
            if (bus.i_alloc_req[k]) begin
               c_req++;
               if (c_req <= m_free.size()) begin
                  exp_gnt[k] = 1'b1;
                  exp_tag[k] = int'(m_free[c_gnt]);
                  c_gnt++;
               end
            end
         end
      end
      chk("m_gnt", int'(bus.o_alloc_gnt), int'(exp_gnt));
      chk("m_tag0", int'(bus.o_alloc_tag[0]), exp_tag[0]);
      chk("m_tag1", int'(bus.o_alloc_tag[1]), exp_tag[1]);
      chk("m_free_cnt", int'(free_cnt), m_ready ? m_free.size() : 0);
      chk("m_ready", int'(ready), int'(m_ready));
      chk("m_empty", int'(empty), int'(m_ready && m_free.size() == 0));
      chk("m_ovf", int'(ovf_err), int'(m_ovf));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_alloc_req = '0;
      bus.i_ret_valid = '0;
      bus.i_ret_tag   = '0;
      flush           = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      bus.i_alloc_req = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", int'(ready), 0);
      chk("rst_cnt", int'(free_cnt), 0);
      chk("rst_gnt", int'(bus.o_alloc_gnt), 0);
      chk("rst_empty", int'(empty), 0);
      rst_n = 1'b1;

      // Reset/init: 16 edges before ready, then tags 0 and 1.
      for (int i = 1; i < INIT_CYC; i++) begin
         tick(); #1;
         chk("init_ready", int'(ready), 0);
         chk("init_gnt", int'(bus.o_alloc_gnt), 0);
      end
      tick(); #1;
      chk("init_done_ready", int'(ready), 1);
      chk("init_done_cnt", int'(free_cnt), 64);
      chk("init_done_gnt", int'(bus.o_alloc_gnt), 3);
      chk("init_tag0", int'(bus.o_alloc_tag[0]), 0);
      chk("init_tag1", int'(bus.o_alloc_tag[1]), 1);

      // Drain: pairs (2j, 2j+1) until empty.
      for (int j = 1; j < 32; j++) begin
         tick(); #1;
         chk("drain_tag0", int'(bus.o_alloc_tag[0]), 2 * j);
         chk("drain_tag1", int'(bus.o_alloc_tag[1]), 2 * j + 1);
      end
      tick(); #1;
      chk("drain_empty", int'(empty), 1);
      chk("drain_gnt", int'(bus.o_alloc_gnt), 0);
      chk("drain_cnt", int'(free_cnt), 0);

      // Empty return of tag 9 on port1, granted next cycle on port0 only.
      bus.i_alloc_req  = 2'b00;
      bus.i_ret_valid  = 2'b10;
      bus.i_ret_tag[1] = 6'd9;
      tick();
      bus.i_ret_valid  = 2'b00;
      bus.i_alloc_req  = 2'b11;
      #1;
      chk("partial_gnt", int'(bus.o_alloc_gnt), 1);
      chk("partial_tag0", int'(bus.o_alloc_tag[0]), 9);
      chk("partial_cnt", int'(free_cnt), 1);
      tick();
      bus.i_alloc_req = 2'b00;
      #1;
      chk("partial_after_cnt", int'(free_cnt), 0);

      // Flush, then flush again during INIT: the 16-cycle count restarts.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (5) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (15) tick();
      #1;
      chk("reinit_ready", int'(ready), 0);
      tick(); #1;
      chk("reinit_done", int'(ready), 1);
      chk("reinit_cnt", int'(free_cnt), 64);

      // Full list: two returns alongside two grants are both accepted.
      bus.i_alloc_req  = 2'b11;
      bus.i_ret_valid  = 2'b11;
      bus.i_ret_tag[0] = 6'd5;
      bus.i_ret_tag[1] = 6'd6;
      #1;
      chk("simul_gnt", int'(bus.o_alloc_gnt), 3);
      tick();
      idle_inputs();
      #1;
      chk("simul_cnt", int'(free_cnt), 64);
      chk("simul_ovf", int'(ovf_err), 0);

      // Overflow: one return into a full list.
      bus.i_ret_valid  = 2'b01;
      bus.i_ret_tag[0] = 6'd3;
      tick();
      idle_inputs();
      #1;
      chk("ovf_set", int'(ovf_err), 1);
      chk("ovf_cnt", int'(free_cnt), 64);

      // Drain to 20, then flush alongside requests and returns.
      bus.i_alloc_req = 2'b11;
      repeat (22) tick();
      bus.i_alloc_req = 2'b00;
      #1;
      chk("mid_cnt", int'(free_cnt), 20);
      flush            = 1'b1;
      bus.i_alloc_req  = 2'b11;
      bus.i_ret_valid  = 2'b11;
      bus.i_ret_tag[0] = 6'd7;
      bus.i_ret_tag[1] = 6'd8;
      #1;
      chk("flush_gnt", int'(bus.o_alloc_gnt), 0);
      tick();
      idle_inputs();
      #1;
      chk("flush_ready", int'(ready), 0);
      chk("flush_cnt", int'(free_cnt), 0);
      chk("flush_ovf_kept", int'(ovf_err), 1);
      repeat (16) tick();
      bus.i_alloc_req = 2'b11;
      #1;
      chk("flush_done_cnt", int'(free_cnt), 64);
      chk("flush_tag0", int'(bus.o_alloc_tag[0]), 0);
      chk("flush_tag1", int'(bus.o_alloc_tag[1]), 1);
      chk("flush_ovf_still", int'(ovf_err), 1);

      // Randomised traffic in alternating allocate-heavy/return-heavy phases.
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (i == 1500) begin
            idle_inputs();
            rst_n = 1'b0;
            tick();
            tick();
            rst_n = 1'b1;
         end
         if (((i / 150) % 2) == 0) begin
            bus.i_alloc_req = 2'($urandom);
            bus.i_ret_valid = 2'($urandom & $urandom);
         end else begin
            bus.i_alloc_req = 2'($urandom & $urandom);
            bus.i_ret_valid = 2'($urandom);
         end
         bus.i_ret_tag[0] = 6'($urandom_range(0, 63));
         bus.i_ret_tag[1] = 6'($urandom_range(0, 63));
         flush = ($urandom_range(0, 99) == 0);
      end
      tick();
      idle_inputs();
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tag_free_list.md
# tag_free_list

Multi-port free list of physical/ROB tags for the out-of-order RISC-V core. Dispatch allocates up to ALLOC_PORTS tags per cycle, and the CDB returns up to RET_PORTS retired tags per cycle. Flush restores the full tag set through a sequential re-initialisation FSM. It replaces the single-port tag FIFO, which had no multi-port access, no free count and no overflow detection.

## Interface
- NUM_TAGS, 64: total tags; power of two, at least 4.
- TAG_W, $clog2(NUM_TAGS): tag width.
- ALLOC_PORTS, 2: allocation ports per cycle.
- RET_PORTS, 2: CDB return ports per cycle.
- INIT_RATE, 4: entries written per init cycle; power of two; divides NUM_TAGS.

- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  pipeline flush; all tags become free.
- i_alloc_req  in  ALLOC_PORTS  per-port allocation request.
- o_alloc_gnt  out  ALLOC_PORTS  per-port grant, combinational.
- o_alloc_tag  out  ALLOC_PORTS×TAG_W  granted tag per port; 0 when not granted.
- i_ret_valid  in  RET_PORTS  per-port tag return valid.
- i_ret_tag  in  RET_PORTS×TAG_W  returned tag.
- o_free_cnt  out  TAG_W+1  free tags, 0..NUM_TAGS.
- o_ready  out  1  list initialised; allocations are accepted.
- o_empty  out  1  o_ready and o_free_cnt==0.
- o_ovf_err  out  1  sticky: a return arrived while the list was full.

## Operation
- **Storage:** circular array of NUM_TAGS×TAG_W, with head pointer hp (TAG_W bits), tail pointer tp (TAG_W bits) and count cnt (TAG_W+1 bits). Pointers wrap modulo NUM_TAGS.
- **FSM states:** INIT, READY.
- **Reset:**
  - state=INIT, init index ii=0, hp=tp=0, cnt=0, o_ovf_err=0.
  - Outputs: o_ready=0, o_alloc_gnt=0, o_alloc_tag=0, o_free_cnt=0, o_empty=0.
- **INIT:**
  - Each cycle writes entries ii..ii+INIT_RATE-1 with values equal to their index, then ii+=INIT_RATE.
  - Grants are forced 0 and returns are ignored.
  - After the last group is written: cnt=NUM_TAGS, hp=0, tp=0, go to READY.
- **READY, allocation:**
  - Port k is granted iff i_alloc_req[k] and (number of requesting ports 0..k) ≤ cnt.
  - Granted port k receives array[hp + rank_k], where rank_k is the count of granted ports below k.
  - hp advances by the number of grants.
- **READY, return:**
  - Valid returns are compacted in port order and written at tp, tp+1, …; tp advances by the number accepted.
  - A return is accepted while cnt − grants + (returns accepted so far) < NUM_TAGS.
  - Excess returns are dropped and set o_ovf_err. Only reset clears o_ovf_err.
- **Count update:** cnt_next = cnt − grants + accepted returns.
- **Same-cycle returns:** a tag returned in cycle t is never allocated in cycle t; there is no bypass.
- **Flush:**
  - Highest priority: grants are forced 0 in that cycle and returns are ignored.
  - Next state is INIT with ii=0, cnt=0. o_ovf_err is preserved.
  - A flush during INIT restarts INIT from ii=0.
- **Reset mid-operation:** asynchronous return to the reset state; INIT restarts from the beginning.

## Timing
- Grants and tags are combinational from i_alloc_req and registered state; pointers and count update on the rising edge.
- INIT lasts NUM_TAGS/INIT_RATE cycles. With defaults, o_ready rises after the 16th rising edge following reset deassertion or a flush edge.
- Return-to-allocate latency:
  - When the list is empty, a tag returned in cycle t is grantable in cycle t+1.
  - In general, tags allocate in FIFO order.
- o_free_cnt and o_empty are registered views of cnt and state, valid the cycle after each update.

## Structure
- **Shared package tag_pkg:**
  - tag_t typedef (logic [TAG_W-1:0]).
  - fl_state_e enum {INIT, READY}.
  - Default constants NUM_TAGS_DEF=64, ALLOC_PORTS_DEF=2, RET_PORTS_DEF=2.
- **Sub-module tag_port_compactor:**
  - Parametrised prefix-count unit giving per-port rank and total count for a valid vector.
  - Instantiated twice: once for allocation grants (with the cnt limit) and once for return compaction.
- Top-level holds the array, pointers, FSM and error flag.

## Test plan
- **Reset/init:** deassert reset, hold requests high → o_ready=0 and no grants for 16 cycles; then o_ready=1, o_free_cnt=64, port0 gets tag 0, port1 gets tag 1.
- **Drain:** request both ports continuously → 32 cycles of tag pairs (0,1)…(62,63); then o_empty=1 and grants 0.
- **Partial grant and empty return:**
  - With cnt=1, request both ports → only port0 granted.
  - At cnt=0, return tag 9 on port1 → the next cycle grants tag 9 on port0.
- **Simultaneous traffic:** with cnt=64, return two tags while allocating two → two accepted, cnt stays 64, o_ovf_err=0.
- **Overflow:** with cnt=64 and no allocation, return one tag → o_ovf_err=1, cnt=64, and the flag stays set across a flush.
- **Flush:**
  - Flush mid-drain (cnt=20) alongside requests and returns → no grants that cycle, 16-cycle INIT, then cnt=64 and allocation restarts at tag 0.
  - A flush during INIT restarts the count.
